rng_poly_sampler: RTL and testbench
===================================

RNG_POLY_SAMPLER -- requirements
Module: rng_poly_sampler

Interface
REQ-001 SHALL have parameter Q, default 17, coefficient modulus.
REQ-002 SHALL have parameter N, default 4, coefficients per polynomial.
REQ-003 SHALL have parameter ETA, default 1, small-noise bound; legal range 1..(Q-1)/2.
REQ-004 SHALL define localparam CW = $clog2(Q), coefficient width (5 at defaults).
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  one-cycle request to sample one polynomial.
REQ-008 mode  in  1  0 = uniform sampling in [0,Q-1]; 1 = small sampling in [-ETA,ETA].
REQ-009 rnd_data  in  32  signed random sample from the generator.
REQ-010 rnd_valid  in  1  rnd_data valid this cycle.
REQ-011 rnd_ready  out  1  sampler consumes rnd_data this cycle; also drives generator enable.
REQ-012 poly_data  out  N*CW  packed coefficients; coefficient i at bits [i*CW +: CW].
REQ-013 poly_valid  out  1  poly_data holds a complete polynomial.
REQ-014 poly_ready  in  1  downstream accepts poly_data.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 reject_cnt  out  16  rejected samples since last accepted start, saturating.

Function
REQ-017 SHALL implement a 3-state FSM: IDLE, COLLECT, HOLD.
REQ-018 IDLE: start=1 -> COLLECT next cycle; mode latched; coefficient index and reject_cnt cleared.
REQ-019 start SHALL be ignored in COLLECT and HOLD; latched mode unaffected.
REQ-020 rnd_ready SHALL be 1 exactly when state is COLLECT (combinational from state).
REQ-021 A transfer SHALL occur only when rnd_valid and rnd_ready are both 1; one sample per cycle max.
REQ-022 Uniform mode: sample v accepted iff 0 <= v <= Q-1; stored as v[CW-1:0].
REQ-023 Small mode: sample v accepted iff -ETA <= v <= ETA; stored as v if v>=0, else v+Q (e.g. -1 -> 16 at Q=17).
REQ-024 Range checks SHALL use signed 32-bit comparison; values outside the range (incl. extreme values 32'h8000_0000, 32'h7FFF_FFFF) SHALL be rejected.
REQ-025 Accepted sample SHALL be written to coefficient slot at current index, index incremented.
REQ-026 Rejected sample SHALL increment reject_cnt, saturating at 16'hFFFF, with no coefficient or index change.
REQ-027 Acceptance into slot N-1 SHALL move FSM to HOLD in the next cycle; rnd_ready low from that cycle.
REQ-028 HOLD: poly_valid=1 and poly_data stable until poly_valid && poly_ready.
REQ-029 Handshake completion in HOLD -> IDLE next cycle; poly_valid deasserts that cycle.
REQ-030 poly_ready SHALL be ignored outside HOLD.
REQ-031 Minimum latency: start at cycle 0, rnd_valid continuously 1 with all samples accepted -> poly_valid at cycle N+1.
REQ-032 poly_data SHALL retain last polynomial in IDLE until the next accepted sample overwrites slot 0.
REQ-033 reject_cnt SHALL hold its value in IDLE and HOLD.
REQ-034 rnd_valid gaps SHALL stall collection with no state change.

Reset
REQ-035 On rising clk with rst_n=0: state IDLE, index 0, mode 0, poly_data 0, reject_cnt 0; hence poly_valid 0, rnd_ready 0, busy 0.
REQ-036 Reset asserted mid-COLLECT or mid-HOLD SHALL discard partial/pending polynomial with no handshake completing.
REQ-037 rst_n SHALL have no effect between clock edges.

Verification
REQ-038 Uniform: start, mode=0, rnd_data 3,16,0,9 on consecutive valid cycles, poly_ready=1 -> poly_valid at cycle 5, coefficients {3,16,0,9}, reject_cnt 0.
REQ-039 Rejection: mode=0, rnd_data -5,17,2,-17,4,1,8 -> coefficients {2,4,1,8}, reject_cnt 3.
REQ-040 Small: mode=1, rnd_data -1,0,1,2,-1 -> coefficients {16,0,1,16}, reject_cnt 1.
REQ-041 Backpressure: poly_ready=0 for 10 cycles in HOLD -> poly_valid and poly_data stable, rnd_ready 0, start pulses ignored; poly_ready=1 -> IDLE next cycle.
REQ-042 Reset mid-operation: rst_n=0 after 2 accepted samples -> next cycle busy 0, poly_data 0, reject_cnt 0; subsequent start collects fresh N samples.
REQ-043 Saturation: 70000 consecutive rejected samples -> reject_cnt stays 16'hFFFF, no wrap.

Source files
------------

// File: rtl/rng_poly_sampler.sv
// Collects N random samples into one polynomial, filtering them by range (uniform or small noise).
// The finished polynomial is held until downstream accepts it.
module rng_poly_sampler #(
  parameter int Q   = 17,
  parameter int N   = 4,
  parameter int ETA = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic signed [31:0]   rnd_data,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  output logic [N*$clog2(Q)-1:0] poly_data,
  output logic                 poly_valid,
  input  logic                 poly_ready,
  output logic                 busy,
  output logic [15:0]          reject_cnt
);

  localparam int CW = $clog2(Q);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  localparam logic signed [31:0] QMAX    = 32'(Q - 1);
  localparam logic signed [31:0] Q_S     = 32'(Q);
  localparam logic signed [31:0] ETA_POS = 32'(ETA);
  localparam logic signed [31:0] ETA_NEG = 32'(-ETA);
  localparam logic [IW-1:0]      LAST    = IW'(N - 1);

  logic [1:0]        state;
  logic              mode_q;
  logic [IW-1:0]     idx;
  logic [N*CW-1:0]   poly_q;
  logic [15:0]       rej_q;
  logic              accept;
  logic [CW-1:0]     coef;

  assign rnd_ready  = (state == COLLECT);
  assign poly_valid = (state == HOLD);
  assign busy       = (state != IDLE);
  assign poly_data  = poly_q;
  assign reject_cnt = rej_q;

  // Negative small-noise samples are stored in their mod-Q representation.
  always_comb begin
    accept = 1'b0;
    coef   = rnd_data[CW-1:0];
    if (mode_q) begin
      accept = (rnd_data >= ETA_NEG) && (rnd_data <= ETA_POS);
      if (rnd_data[31])
        coef = CW'(rnd_data + Q_S);
    end else begin
      accept = (rnd_data >= 32'sd0) && (rnd_data <= QMAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      mode_q <= 1'b0;
      idx    <= '0;
      poly_q <= '0;
      rej_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= COLLECT;
            mode_q <= mode;
            idx    <= '0;
            rej_q  <= '0;
          end
        end
        COLLECT: begin
          if (rnd_valid) begin
            if (accept) begin
              poly_q[idx*CW +: CW] <= coef;
              idx                  <= idx + 1'b1;
              if (idx == LAST)
                state <= HOLD;
            end else if (rej_q != 16'hFFFF) begin
              rej_q <= rej_q + 16'd1;
            end
          end
        end
        HOLD: begin
          if (poly_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_poly_sampler.sv
// Directed self-checking bench for rng_poly_sampler at default parameters (Q=17, N=4, ETA=1).
module tb_rng_poly_sampler;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               mode;
  logic signed [31:0] rnd_data;
  logic               rnd_valid;
  logic               rnd_ready;
  logic [19:0]        poly_data;
  logic               poly_valid;
  logic               poly_ready;
  logic               busy;
  logic [15:0]        reject_cnt;

  int checks = 0;
  int failures = 0;

  rng_poly_sampler #(.Q(17), .N(4), .ETA(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .rnd_data   (rnd_data),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .poly_data  (poly_data),
    .poly_valid (poly_valid),
    .poly_ready (poly_ready),
    .busy       (busy),
    .reject_cnt (reject_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic signed [31:0] d);
    rnd_valid = 1'b1;
    rnd_data  = d;
    step();
    rnd_valid = 1'b0;
  endtask

  task automatic startPoly(input logic m);
    start = 1'b1;
    mode  = m;
    step();
    start = 1'b0;
  endtask

  function automatic logic [19:0] pk(input logic [4:0] c0, input logic [4:0] c1,
                                     input logic [4:0] c2, input logic [4:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  logic signed [31:0] extremes [4];

  initial begin
    extremes[0] = -32'sd1;
    extremes[1] = 32'sd17;
    extremes[2] = 32'sh8000_0000;
    extremes[3] = 32'sh7FFF_FFFF;

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; rnd_data = '0; rnd_valid = 1'b0; poly_ready = 1'b0;
    step(); step();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_poly_valid", 32'(poly_valid), 32'd0);
    checkOutput("rst_rnd_ready", 32'(rnd_ready), 32'd0);
    checkOutput("rst_poly_data", 32'(poly_data), 32'd0);
    checkOutput("rst_reject", 32'(reject_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    // Uniform vector with minimum latency
    poly_ready = 1'b1;
    startPoly(1'b0);
    checkOutput("u_busy", 32'(busy), 32'd1);
    checkOutput("u_rnd_ready", 32'(rnd_ready), 32'd1);
    applyStimulus(32'sd3);
    applyStimulus(32'sd16);
    applyStimulus(32'sd0);
    checkOutput("u_valid_early", 32'(poly_valid), 32'd0);
    applyStimulus(32'sd9);
    checkOutput("u_valid", 32'(poly_valid), 32'd1);
    checkOutput("u_data", 32'(poly_data), 32'(pk(5'd3, 5'd16, 5'd0, 5'd9)));
    checkOutput("u_reject", 32'(reject_cnt), 32'd0);
    checkOutput("u_hold_rnd_ready", 32'(rnd_ready), 32'd0);
    step();
    checkOutput("u_idle_valid", 32'(poly_valid), 32'd0);
    checkOutput("u_idle_busy", 32'(busy), 32'd0);
    checkOutput("u_idle_data_kept", 32'(poly_data), 32'(pk(5'd3, 5'd16, 5'd0, 5'd9)));

    // Rejection vector followed by backpressure in HOLD
    poly_ready = 1'b0;
    startPoly(1'b0);
    applyStimulus(-32'sd5);
    applyStimulus(32'sd17);
    applyStimulus(32'sd2);
    applyStimulus(-32'sd17);
    applyStimulus(32'sd4);
    applyStimulus(32'sd1);
    applyStimulus(32'sd8);
    checkOutput("r_valid", 32'(poly_valid), 32'd1);
    checkOutput("r_data", 32'(poly_data), 32'(pk(5'd2, 5'd4, 5'd1, 5'd8)));
    checkOutput("r_reject", 32'(reject_cnt), 32'd3);
    for (int i = 0; i < 10; i++) begin
      start = 1'b1;
      mode  = i[0];
      step();
      checkOutput("bp_valid", 32'(poly_valid), 32'd1);
      checkOutput("bp_data", 32'(poly_data), 32'(pk(5'd2, 5'd4, 5'd1, 5'd8)));
      checkOutput("bp_rnd_ready", 32'(rnd_ready), 32'd0);
      checkOutput("bp_reject", 32'(reject_cnt), 32'd3);
    end
    start = 1'b0;
    poly_ready = 1'b1;
    step();
    checkOutput("bp_release_valid", 32'(poly_valid), 32'd0);
    checkOutput("bp_release_busy", 32'(busy), 32'd0);
    poly_ready = 1'b0;

    // Small mode, with mode input flipped after start and a valid gap
    startPoly(1'b1);
    mode = 1'b0;
    applyStimulus(-32'sd1);
    applyStimulus(32'sd0);
    rnd_data = 32'sd5;
    step(); step();
    checkOutput("gap_busy", 32'(busy), 32'd1);
    checkOutput("gap_reject", 32'(reject_cnt), 32'd0);
    checkOutput("gap_valid", 32'(poly_valid), 32'd0);
    applyStimulus(32'sd1);
    applyStimulus(32'sd2);
    applyStimulus(-32'sd1);
    checkOutput("s_valid", 32'(poly_valid), 32'd1);
    checkOutput("s_data", 32'(poly_data), 32'(pk(5'd16, 5'd0, 5'd1, 5'd16)));
    checkOutput("s_reject", 32'(reject_cnt), 32'd1);
    poly_ready = 1'b1;
    step();
    poly_ready = 1'b0;

    // Reset in the middle of collection, then a fresh polynomial
    startPoly(1'b0);
    applyStimulus(32'sd5);
    applyStimulus(32'sd99);
    applyStimulus(32'sd6);
    checkOutput("pre_rst_reject", 32'(reject_cnt), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_data", 32'(poly_data), 32'd0);
    checkOutput("mid_rst_reject", 32'(reject_cnt), 32'd0);
    checkOutput("mid_rst_valid", 32'(poly_valid), 32'd0);
    startPoly(1'b0);
    applyStimulus(32'sd1);
    applyStimulus(32'sd2);
    applyStimulus(32'sd3);
    applyStimulus(32'sd4);
    checkOutput("fresh_data", 32'(poly_data), 32'(pk(5'd1, 5'd2, 5'd3, 5'd4)));
    checkOutput("fresh_valid", 32'(poly_valid), 32'd1);
    // A reset pulse between edges must not be seen
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    checkOutput("glitch_valid", 32'(poly_valid), 32'd1);
    checkOutput("glitch_data", 32'(poly_data), 32'(pk(5'd1, 5'd2, 5'd3, 5'd4)));
    poly_ready = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    poly_ready = 1'b0;
    checkOutput("hold_rst_valid", 32'(poly_valid), 32'd0);
    checkOutput("hold_rst_data", 32'(poly_data), 32'd0);

    // Saturating reject counter, fed only out-of-range and extreme values
    startPoly(1'b0);
    for (int i = 0; i < 70000; i++) begin
      applyStimulus(extremes[i % 4]);
      if (i == 65533)
        checkOutput("sat_below", 32'(reject_cnt), 32'h0000_FFFE);
      if (i == 65534)
        checkOutput("sat_reach", 32'(reject_cnt), 32'h0000_FFFF);
    end
    checkOutput("sat_final", 32'(reject_cnt), 32'h0000_FFFF);
    checkOutput("sat_busy", 32'(busy), 32'd1);
    checkOutput("sat_rnd_ready", 32'(rnd_ready), 32'd1);
    checkOutput("sat_data", 32'(poly_data), 32'd0);
    rst_n = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
